apb_uart_csr: RTL and testbench

// - APB3 completer (slave end) for the UART control/status registers.
// - Decodes APB accesses and inserts a configurable number of wait states on pready.
// - Pushes writes of TXDATA into the UART TX FIFO and pops the RX FIFO on reads of RXDATA.
// - Holds CTRL and BAUD_DIV, and drives them to the UART core. Sits between the APB bus and the UART TX/RX datapath.

---
 rtl/apb_uart_csr.sv | 122 ++++++++++++
 tb/tb_apb_uart_csr.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_csr.sv
// APB3 completer for the UART control/status registers: wait-state FSM,
// TX push / RX pop strobes, sticky overflow/underflow flags, CTRL and BAUD_DIV.
module apb_uart_csr #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BAUD_RST    = 32'h0000_0036
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        tx_push,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  output logic        rx_pop,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic [7:0]  ctrl,
  output logic [31:0] baud_div
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_commit;
  logic        r_tx_ovf, r_rx_udf;

  logic        w_mapped;
  logic [2:0]  w_idx;
  logic        w_wr_tx, w_wr_stat, w_wr_ctrl, w_wr_baud, w_rd_rx;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = &{1'b0, paddr[1:0]};

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Dropping psel in WAIT aborts the transfer before anything is committed.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE: if (psel && penable) begin
        w_next    = S_WAIT;
        w_cnt_nxt = WAIT_STATES[3:0];
      end
      S_WAIT: begin
        if (!psel)             w_next = S_IDLE;
        else if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
        else begin
          w_next   = S_DONE;
          w_commit = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_mapped  = (paddr[31:5] == 27'd0) && (paddr[4:2] <= 3'd4);
  assign w_idx     = paddr[4:2];
  assign w_wr_tx   = w_commit &&  pwrite && w_mapped && (w_idx == 3'd0);
  assign w_rd_rx   = w_commit && !pwrite && w_mapped && (w_idx == 3'd1);
  assign w_wr_stat = w_commit &&  pwrite && w_mapped && (w_idx == 3'd2);
  assign w_wr_ctrl = w_commit &&  pwrite && w_mapped && (w_idx == 3'd3);
  assign w_wr_baud = w_commit &&  pwrite && w_mapped && (w_idx == 3'd4);

  always_comb begin
    w_rdata = 32'd0;
    if (w_mapped) begin
      case (w_idx)
        3'd1:    w_rdata = rx_empty ? 32'd0 : {24'd0, rx_data};
        3'd2:    w_rdata = {27'd0, r_rx_udf, r_tx_ovf, rx_empty, tx_full, 1'b0};
        3'd3:    w_rdata = {24'd0, ctrl};
        3'd4:    w_rdata = baud_div;
        default: w_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      pready   <= 1'b0;
      prdata   <= 32'd0;
      tx_push  <= 1'b0;
      tx_data  <= 8'd0;
      rx_pop   <= 1'b0;
      ctrl     <= 8'd0;
      baud_div <= BAUD_RST;
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      pready  <= w_commit;
      tx_push <= w_wr_tx && !tx_full;
      rx_pop  <= w_rd_rx && !rx_empty;
      if (w_wr_tx && !tx_full) tx_data <= pwdata[7:0];
      if (w_commit && !pwrite) prdata <= w_rdata;
      if (w_wr_ctrl) ctrl     <= pwdata[7:0];
      if (w_wr_baud) baud_div <= pwdata;
      // Set has priority over a W1C clear landing on the same edge.
      if (w_wr_tx && tx_full)              r_tx_ovf <= 1'b1;
      else if (w_wr_stat && pwdata[3])     r_tx_ovf <= 1'b0;
      if (w_rd_rx && rx_empty)             r_rx_udf <= 1'b1;
      else if (w_wr_stat && pwdata[4])     r_rx_udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_uart_csr.sv
// Self-checking bench for apb_uart_csr: read data is checked against a queue
// of expected values pushed when each read is issued.
module tb_apb_uart_csr;

  logic        pclk, rst;
  logic [31:0] paddr, pwdata, prdata, baud_div;
  logic        psel, penable, pwrite, pready;
  logic        tx_push, tx_full, rx_pop, rx_empty;
  logic [7:0]  tx_data, rx_data, ctrl;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  apb_uart_csr #(.WAIT_STATES(2), .BAUD_RST(32'h0000_0036)) dut (
    .pclk(pclk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .rx_pop(rx_pop),
    .rx_data(rx_data), .rx_empty(rx_empty), .ctrl(ctrl), .baud_div(baud_div)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Full APB transfer; caller sits #1 after a posedge. Counts edges from the
  // first penable edge to pready and strobe pulses through one cycle after.
  task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rd, output int edges,
                     output int pushes, output int pops, output logic push_at_rdy);
    rd = 32'd0; edges = 0; pushes = 0; pops = 0; push_at_rdy = 1'b0;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(posedge pclk); #1 penable = 1'b1;
    while (edges < 40) begin
      @(posedge pclk); #1;
      edges++;
      pushes += int'(tx_push);
      pops   += int'(rx_pop);
      if (pready) begin
        rd = prdata;
        push_at_rdy = tx_push;
        break;
      end
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    pushes += int'(tx_push);
    pops   += int'(rx_pop);
  endtask

  task automatic test_reset();
    total++;
    if ({pready, tx_push, rx_pop} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes got=%b want=000", {pready, tx_push, rx_pop});
    end
    total++;
    if (prdata !== 32'd0 || tx_data !== 8'd0 || ctrl !== 8'd0) begin
      bad++; $display("FAIL reset_regs prdata=%h tx_data=%h ctrl=%h want 0", prdata, tx_data, ctrl);
    end
    total++;
    if (baud_div !== 32'h0000_0036) begin
      bad++; $display("FAIL reset_baud got=%h want=00000036", baud_div);
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd, e; int n, pu, po; logic pr;
    apb(32'h0C, 1'b1, 32'h03, rd, n, pu, po, pr);
    total++;
    if (n !== 4) begin bad++; $display("FAIL ctrl_latency got=%0d want=4", n); end
    total++;
    if (ctrl !== 8'h03) begin bad++; $display("FAIL ctrl_write got=%h want=03", ctrl); end
    exp_q.push_back(32'h0000_0003);
    apb(32'h0C, 1'b0, 32'h0, rd, n, pu, po, pr);
    e = exp_q.pop_front();
    total++;
    if (rd !== e || n !== 4) begin
      bad++; $display("FAIL ctrl_read got=%h/%0d want=%h/4", rd, n, e);
    end
  endtask

  task automatic test_baud();
    logic [31:0] rd, e; int n, pu, po; logic pr;
    apb(32'h10, 1'b1, 32'h1234_5678, rd, n, pu, po, pr);
    total++;
    if (baud_div !== 32'h1234_5678) begin
      bad++; $display("FAIL baud_write got=%h want=12345678", baud_div);
    end
    exp_q.push_back(32'h1234_5678);
    apb(32'h13, 1'b0, 32'h0, rd, n, pu, po, pr);
    e = exp_q.pop_front();
    total++;
    if (rd !== e) begin bad++; $display("FAIL baud_read got=%h want=%h", rd, e); end
  endtask

  task automatic test_tx();
    logic [31:0] rd, e; int n, pu, po; logic pr;
    tx_full = 1'b0;
    apb(32'h00, 1'b1, 32'h1A5, rd, n, pu, po, pr);
    total++;
    if (pu !== 1 || pr !== 1'b1) begin
      bad++; $display("FAIL tx_push pulses=%0d at_ready=%b want 1/1", pu, pr);
    end
    total++;
    if (tx_data !== 8'hA5) begin bad++; $display("FAIL tx_data got=%h want=a5", tx_data); end
    exp_q.push_back(32'd0);
    apb(32'h00, 1'b0, 32'h0, rd, n, pu, po, pr);
    e = exp_q.pop_front();
    total++;
    if (rd !== e) begin bad++; $display("FAIL txdata_read got=%h want=%h", rd, e); end
  endtask

  task automatic test_tx_ovf();
    logic [31:0] rd, e; int n, pu, po; logic pr;
    tx_full = 1'b1; rx_empty = 1'b0;
    apb(32'h00, 1'b1, 32'h77, rd, n, pu, po, pr);
    total++;
    if (pu !== 0 || tx_data !== 8'hA5) begin
      bad++; $display("FAIL tx_full_push pulses=%0d tx_data=%h want 0/a5", pu, tx_data);
    end
    exp_q.push_back(32'h0000_000A);
    apb(32'h08, 1'b0, 32'h0, rd, n, pu, po, pr);
    e = exp_q.pop_front();
    total++;
    if (rd !== e) begin bad++; $display("FAIL status_ovf got=%h want=%h", rd, e); end
    apb(32'h08, 1'b1, 32'h08, rd, n, pu, po, pr);
    exp_q.push_back(32'h0000_0002);
    apb(32'h08, 1'b0, 32'h0, rd, n, pu, po, pr);
    e = exp_q.pop_front();
    total++;
    if (rd !== e) begin bad++; $display("FAIL status_w1c got=%h want=%h", rd, e); end
    tx_full = 1'b0;
  endtask

  task automatic test_rx();
    logic [31:0] rd, e; int n, pu, po; logic pr;
    rx_data = 8'h5C; rx_empty = 1'b0;
    exp_q.push_back(32'h0000_005C);
    apb(32'h04, 1'b0, 32'h0, rd, n, pu, po, pr);
    e = exp_q.pop_front();
    total++;
    if (rd !== e || po !== 1) begin
      bad++; $display("FAIL rx_read got=%h pops=%0d want=%h/1", rd, po, e);
    end
    rx_empty = 1'b1;
    exp_q.push_back(32'd0);
    apb(32'h04, 1'b0, 32'h0, rd, n, pu, po, pr);
    e = exp_q.pop_front();
    total++;
    if (rd !== e || po !== 0) begin
      bad++; $display("FAIL rx_empty_read got=%h pops=%0d want=%h/0", rd, po, e);
    end
    exp_q.push_back(32'h0000_0014);
    apb(32'h08, 1'b0, 32'h0, rd, n, pu, po, pr);
    e = exp_q.pop_front();
    total++;
    if (rd !== e) begin bad++; $display("FAIL status_udf got=%h want=%h", rd, e); end
    apb(32'h08, 1'b1, 32'h10, rd, n, pu, po, pr);
    exp_q.push_back(32'h0000_0004);
    apb(32'h08, 1'b0, 32'h0, rd, n, pu, po, pr);
    e = exp_q.pop_front();
    total++;
    if (rd !== e) begin bad++; $display("FAIL status_udf_clr got=%h want=%h", rd, e); end
    rx_empty = 1'b0;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd, e; int n, pu, po; logic pr;
    exp_q.push_back(32'd0);
    apb(32'h40, 1'b0, 32'h0, rd, n, pu, po, pr);
    e = exp_q.pop_front();
    total++;
    if (rd !== e || n !== 4) begin
      bad++; $display("FAIL unmapped_read got=%h/%0d want=%h/4", rd, n, e);
    end
    apb(32'h40, 1'b1, 32'hFFFF_FFFF, rd, n, pu, po, pr);
    total++;
    if (ctrl !== 8'h03 || baud_div !== 32'h1234_5678 || pu !== 0) begin
      bad++; $display("FAIL unmapped_write ctrl=%h baud=%h push=%0d want 03/12345678/0", ctrl, baud_div, pu);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, e, v; int n, pu, po; logic pr;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      apb(32'h10, 1'b1, v, rd, n, pu, po, pr);
      exp_q.push_back(v);
      apb(32'h10, 1'b0, 32'h0, rd, n, pu, po, pr);
      e = exp_q.pop_front();
      total++;
      if (rd !== e) begin bad++; $display("FAIL b2b_baud[%0d] got=%h want=%h", i, rd, e); end
    end
    apb(32'h10, 1'b1, 32'h1234_5678, rd, n, pu, po, pr);
  endtask

  task automatic test_abort();
    int rdy = 0, pu = 0;
    tx_full = 1'b0;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'h3C;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge pclk); #1;
      rdy += int'(pready); pu += int'(tx_push);
    end
    total++;
    if (rdy !== 0 || pu !== 0 || tx_data !== 8'hA5) begin
      bad++; $display("FAIL abort ready=%0d push=%0d tx_data=%h want 0/0/a5", rdy, pu, tx_data);
    end
  endtask

  task automatic test_reset_mid();
    int ev = 0;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'h99;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1 rst = 1'b1;
    #1;
    total++;
    if (baud_div !== 32'h36 || ctrl !== 8'h00 || pready !== 1'b0 || tx_data !== 8'h00) begin
      bad++; $display("FAIL reset_mid baud=%h ctrl=%h ready=%b tx_data=%h", baud_div, ctrl, pready, tx_data);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      ev += int'(pready) + int'(tx_push) + int'(rx_pop);
    end
    total++;
    if (ev !== 0) begin bad++; $display("FAIL reset_mid_strobes got=%0d want=0", ev); end
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; tx_full = 1'b0; rx_empty = 1'b0; rx_data = 8'd0;
    @(posedge pclk); #1;
    test_reset();
    rst = 1'b0;
    @(posedge pclk); #1;
    test_ctrl();
    test_baud();
    test_tx();
    test_tx_ovf();
    test_rx();
    test_unmapped();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
